// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction-fetch stage. It holds the PC and a synchronous-read
//            instruction memory, and presents one instruction per cycle with
//            a valid flag. It supports stall, redirect, halt detection and a
//            one-entry skid register.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    output logic              halted
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rd_inflight_q, rd_inflight_d;
    logic [31:0] rd_pc_q, rd_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;

    logic        running, skid_avail, rd_avail, out_load, issue, load_halt;
    logic [31:0] src_word;

    // The low two bits of the redirect target are dropped on purpose.
    logic        unused_bits;
    assign unused_bits = ^redirect_pc[1:0];

    // Instruction memory: writes are always honoured, and the read is
    // registered. The read sees the old word when a write hits the same address.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem_q[imem_waddr] <= imem_wdata;
        end
        rdata_q <= mem_q[pc_q[ADDR_W+1:2]];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect always restarts, and presenting HALT_WORD stops
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = ST_RUN;
        end else if (load_halt) begin
            state_d = ST_HALT;
        end
    end

    // FSM outputs: issue control and source availability. In HALT, pending
    // data is treated as discarded.
    always_comb begin
        running    = (state_q == ST_RUN);
        skid_avail = skid_valid_q && running;
        rd_avail   = rd_inflight_q && running;
        out_load   = !inst_valid_q || !stall;
        issue      = running && !skid_valid_q && !(stall && rd_inflight_q && inst_valid_q);
        src_word   = skid_avail ? skid_inst_q : rdata_q;
        load_halt  = out_load && (skid_avail || rd_avail) && (src_word == HALT_WORD);
    end

    // Datapath next state: PC, in-flight tag, skid entry and output register
    always_comb begin
        pc_d          = pc_q;
        rd_inflight_d = 1'b0;
        rd_pc_d       = rd_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_inst_d   = skid_inst_q;
        skid_pc_d     = skid_pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        if (redirect) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            skid_valid_d = 1'b0;
            inst_valid_d = 1'b0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                rd_inflight_d = 1'b1;
                rd_pc_d       = pc_q;
            end
            if (out_load) begin
                if (skid_avail) begin
                    inst_d       = skid_inst_q;
                    inst_pc_d    = skid_pc_q;
                    inst_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (rd_avail) begin
                    inst_d       = rdata_q;
                    inst_pc_d    = rd_pc_q;
                    inst_valid_d = 1'b1;
                end else begin
                    inst_valid_d = 1'b0;
                end
            end else if (rd_avail) begin
                // The output is held, so the returning read parks in the skid.
                skid_valid_d = 1'b1;
                skid_inst_d  = rdata_q;
                skid_pc_d    = rd_pc_q;
            end
            if (!running) begin
                skid_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            rd_inflight_q <= 1'b0;
            rd_pc_q       <= 32'd0;
            skid_valid_q  <= 1'b0;
            skid_inst_q   <= 32'd0;
            skid_pc_q     <= 32'd0;
            inst_q        <= 32'd0;
            inst_pc_q     <= 32'd0;
            inst_valid_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            rd_inflight_q <= rd_inflight_d;
            rd_pc_q       <= rd_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_inst_q   <= skid_inst_d;
            skid_pc_q     <= skid_pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign halted     = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Directed self-checking bench for inst_fetch. It covers the reset
//            flow, stall and skid, redirect, halt, PC wrap and asynchronous
//            reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_we, imem_we_w;
    logic [7:0]  imem_waddr;
    logic [1:0]  imem_waddr_w;
    logic [31:0] imem_wdata;
    logic        stall, redirect, redirect_w;
    logic [31:0] redirect_pc;
    logic [31:0] inst, inst_pc, inst_w, inst_pc_w;
    logic        inst_valid, halted, inst_valid_w, halted_w;

    int vectors;
    int miscompares;

    inst_fetch #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .halted(halted)
    );

    inst_fetch #(.ADDR_W(2)) dut_w (
        .clk(clk), .rst(rst), .imem_we(imem_we_w), .imem_waddr(imem_waddr_w),
        .imem_wdata(imem_wdata), .stall(stall), .redirect(redirect_w),
        .redirect_pc(redirect_pc), .inst(inst_w), .inst_pc(inst_pc_w),
        .inst_valid(inst_valid_w), .halted(halted_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic wrw(input logic [1:0] a, input logic [31:0] d);
        imem_we_w = 1'b1; imem_waddr_w = a; imem_wdata = d;
        tick();
        imem_we_w = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_inst"}, inst, ei);
        chk({tag, "_pc"}, inst_pc, ep);
    endtask

    logic [31:0] wrap_exp [6];

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_w = 1'b0;
        redirect_pc = 32'd0; imem_we = 1'b0; imem_we_w = 1'b0;
        imem_waddr = 8'd0; imem_waddr_w = 2'd0; imem_wdata = 32'd0;
        wrap_exp = '{32'hA2, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 32'hA3};

        // Memory loads while reset is held; contents survive reset.
        wr(8'd0, 32'h11); wr(8'd1, 32'h22); wr(8'd2, 32'h33); wr(8'd3, 32'h44);
        wr(8'd16, 32'h1600);
        wrw(2'd0, 32'hA0); wrw(2'd1, 32'hA1); wrw(2'd2, 32'hA2); wrw(2'd3, 32'hA3);

        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Reset flow: the first valid instruction appears at the 2nd edge.
        rst = 1'b0;
        tick();
        chk("edge1_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk_out("flow0", 32'h11, 32'd0);
        tick();
        chk_out("flow1", 32'h22, 32'd4);

        // Stall while (0x22,4) is presented.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall_hold", 32'h22, 32'd4);
        end
        chk("skid_full", {31'd0, dut.skid_valid_q}, 32'd1);
        stall = 1'b0;
        tick();
        chk_out("after_stall", 32'h33, 32'd8);
        tick();
        tick();
        chk_out("next_after_skid", 32'h44, 32'd12);

        // Redirect while stalled: the low two bits of the target are ignored.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0043;
        tick();
        chk("redir_valid0", {31'd0, inst_valid}, 32'd0);
        redirect = 1'b0;
        tick();
        chk("redir_valid1", {31'd0, inst_valid}, 32'd0);
        tick();
        chk_out("redir_target", 32'h1600, 32'h40);
        stall = 1'b0;

        // Halt: place HALT_WORD at word 3 and restart from 0.
        wr(8'd3, 32'hFFFF_FFFF);
        redirect = 1'b1; redirect_pc = 32'd0;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk_out("halt_run0", 32'h11, 32'd0);
        tick();
        chk_out("halt_run1", 32'h22, 32'd4);
        tick();
        chk_out("halt_run2", 32'h33, 32'd8);
        tick();
        chk_out("halt_word", 32'hFFFF_FFFF, 32'd12);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_valid", {31'd0, inst_valid}, 32'd0);
            chk("halt_pc_frozen", dut.pc_q, 32'd20);
        end
        chk("halt_still", {31'd0, halted}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'd0;
        tick();
        chk("unhalt", {31'd0, halted}, 32'd0);
        redirect = 1'b0;
        tick();
        tick();
        chk_out("restart", 32'h11, 32'd0);

        // Fill the skid, then assert reset asynchronously between edges.
        stall = 1'b1;
        tick();
        chk("skid_full2", {31'd0, dut.skid_valid_q}, 32'd1);
        chk_out("skid_hold", 32'h11, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_inst", inst, 32'd0);
        chk("arst_pc", inst_pc, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        tick();
        rst = 1'b0; stall = 1'b0;
        tick();
        chk("arst_edge1", {31'd0, inst_valid}, 32'd0);
        tick();
        chk_out("arst_restart", 32'h11, 32'd0);

        // Wrap on the 4-word instance starting at pc 8.
        redirect_w = 1'b1; redirect_pc = 32'd8;
        tick();
        redirect_w = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wrap_valid", {31'd0, inst_valid_w}, 32'd1);
            chk("wrap_inst", inst_w, wrap_exp[i]);
            chk("wrap_pc", inst_pc_w, 32'd8 + 32'(4 * i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the decode/register-file stage and drives its 32-bit `inst` input.
- Holds the program counter and a synchronous-read instruction memory that the bench or loader can write.
- Presents one instruction per cycle with a valid flag, a stall hold, a branch/jump redirect, and a halt detect.
- A one-entry skid register guarantees no instruction is dropped or duplicated across stalls.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory (depth = 2**ADDR_W words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetching once it is presented.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_we  input  1  instruction-memory write enable.
- imem_waddr  input  ADDR_W  memory write word address.
- imem_wdata  input  32  memory write data.
- stall  input  1  downstream cannot accept; hold the outputs.
- redirect  input  1  load a new PC and flush the stage.
- redirect_pc  input  32  target byte address; bits [1:0] are ignored and treated as 00.
- inst  output  32  instruction to decode.
- inst_pc  output  32  byte address of `inst`.
- inst_valid  output  1  `inst` / `inst_pc` are meaningful.
- halted  output  1  HALT_WORD has been presented; fetching stopped.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect):
  - pc_q = RESET_PC; state = RUN.
  - In-flight read tag, skid valid, and inst_valid = 0.
  - inst = 0, inst_pc = 0, halted = 0.
  - Memory contents are NOT cleared.
- Memory:
  - Read address is pc_q[ADDR_W+1:2]; read data is registered, giving 1-cycle latency.
  - A write to the address being read in the same cycle returns the old data.
  - PC indices above the depth wrap naturally through truncation.
- Issue:
  - issue = (state==RUN) && !skid_valid && !(stall && rd_inflight && inst_valid).
  - On issue: pc_q <= pc_q + 4, and a read is tagged in flight with its pc.
- Output register:
  - Loads when !inst_valid || !stall.
  - Source priority: skid entry first, then the returning read.
  - inst_valid is cleared when the register loads and neither source is available.
- Skid:
  - A read returns while the output is valid and stalled: the data goes into the skid (skid_valid = 1).
  - The skid drains into the output on the first non-stalled cycle.
- Ordering: instructions leave strictly in PC order; no duplicates, no losses.
- Latency and throughput:
  - The first valid instruction appears at the 2nd rising edge after rst deasserts.
  - Sustained throughput is 1 instruction/cycle with stall low.
- Stall: inst, inst_pc, and inst_valid hold exactly while stall = 1 and inst_valid = 1.
- Redirect (highest priority after reset; overrides stall and HALT):
  - At the edge: pc_q <= {redirect_pc[31:2],2'b00}.
  - In-flight read and skid are discarded; inst_valid <= 0; state <= RUN; halted <= 0.
  - The target instruction is valid 2 edges after the redirect edge.
  - Redirect held for several cycles reloads each cycle, so the output stays invalid.
- Halt:
  - When the output register loads HALT_WORD, state <= HALT and halted <= 1 on the same edge.
  - HALT_WORD is presented with inst_valid = 1 like any instruction and honours stall.
  - Once it is consumed (no stall), inst_valid <= 0.
  - In HALT: no issue; in-flight read and skid are discarded.
  - Exit only by redirect or reset.
- Simultaneous events:
  - Redirect and stall in the same cycle: redirect wins.
  - Redirect and HALT_WORD arrival in the same cycle: redirect wins, and halted stays 0.
  - imem_we during any state is always honoured.

Test Plan:
- Reset flow: load words 0x11,0x22,0x33 at addresses 0..2, release rst, stall = 0.
  - Required: inst_valid rises at the 2nd edge.
  - Required: inst/inst_pc sequence (0x11,0),(0x22,4),(0x33,8) on consecutive cycles.
- Stall mid-stream: assert stall for 3 cycles while (0x22,4) is presented.
  - Required: output holds (0x22,4) through all 3 cycles.
  - Required: after release, (0x33,8) appears next cycle with no gap or duplicate; skid observed full.
- Redirect: pulse redirect with redirect_pc = 0x0000_0043 while stalled.
  - Required: inst_valid = 0 the next cycle, and stall is ignored.
  - Required: 2 edges later, inst_pc = 0x40 with mem[16].
- Halt: mem[3] = HALT_WORD; run from 0.
  - Required: 0xFFFFFFFF is presented at pc 12 with halted = 1.
  - Required: inst_valid = 0 afterwards and pc_q frozen for 10 cycles.
  - Required: a redirect to 0 restarts with halted = 0.
- Wrap: ADDR_W = 2; run 6 instructions from pc 8.
  - Required: inst repeats mem[2],mem[3],mem[0],mem[1]… while inst_pc keeps counting 8,12,16,20.
- Async reset mid-operation: assert rst between edges during a stall with the skid full.
  - Required: all outputs go to 0 immediately, with no clock edge needed.
  - Required: restart fetches from RESET_PC.
